adc_stream_packer: RTL

//  Downstream of the ADC SPI manager: consumes its 32-bit conversion stream, optionally averages
//  2^N consecutive samples, packs two 32-bit results per 64-bit beat and marks tlast every
//  cfg_block_len beats so the AXI DMA writes fixed-size blocks. Single clock domain (aclk).

---
 rtl/adc_stream_packer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/adc_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : adc_stream_packer
// Description : Averages 2^N ADC samples, packs two 32-bit results per 64-bit
//               AXI-Stream beat and marks tlast at fixed DMA block boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_stream_packer #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int MAX_AVG_LOG2 = 8
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cfg_enable,
  input  logic [3:0]  cfg_avg_log2,
  input  logic [15:0] cfg_block_len,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [31:0] status
);

  localparam int         ACC_W = SAMPLE_WIDTH + MAX_AVG_LOG2;
  localparam int         CNT_W = (MAX_AVG_LOG2 > 0) ? MAX_AVG_LOG2 : 1;
  localparam logic [3:0] MAX_N = 4'(MAX_AVG_LOG2);

  logic                    enable_q;
  logic                    enable_rise;
  logic [3:0]              avg_n;
  logic [15:0]             blen_m1;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        avg_cnt;
  logic                    lane;
  logic [31:0]             low_word;
  logic [15:0]             beat_cnt;
  logic [15:0]             block_cnt;

  logic                           in_xfer;
  logic                           out_xfer;
  logic signed [SAMPLE_WIDTH-1:0] sample;
  logic signed [ACC_W-1:0]        sample_ext;
  logic signed [ACC_W-1:0]        acc_sum;
  logic signed [ACC_W-1:0]        avg_val;
  logic [CNT_W:0]                 pow2;
  logic [CNT_W-1:0]               avg_top;
  logic                           avg_done;
  logic [31:0]                    result;
  logic                           beat_load;
  logic                           beat_last;
  logic [3:0]                     n_clamped;

  generate
    if (SAMPLE_WIDTH < 32) begin : g_unused_tdata
      logic unused_tdata_bits;
      assign unused_tdata_bits = ^s_axis_tdata[31:SAMPLE_WIDTH];
    end
  endgenerate

  assign enable_rise   = cfg_enable & ~enable_q;
  assign s_axis_tready = enable_q & (~m_axis_tvalid | m_axis_tready);
  assign in_xfer       = s_axis_tvalid & s_axis_tready;
  assign out_xfer      = m_axis_tvalid & m_axis_tready;
  assign n_clamped     = (cfg_avg_log2 > MAX_N) ? MAX_N : cfg_avg_log2;

  // Size casts of signed operands sign-extend (or truncate) as needed.
  always_comb begin
    sample     = s_axis_tdata[SAMPLE_WIDTH-1:0];
    sample_ext = ACC_W'(sample);
    acc_sum    = acc + sample_ext;
    avg_val    = acc_sum >>> avg_n;
    result     = 32'(avg_val);
    pow2       = (CNT_W+1)'(1) << avg_n;
    avg_top    = CNT_W'(pow2 - (CNT_W+1)'(1));
    avg_done   = (avg_cnt == avg_top);
    beat_load  = in_xfer & avg_done & lane;
    beat_last  = (beat_cnt == blen_m1);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      enable_q <= 1'b0;
      avg_n    <= '0;
      blen_m1  <= '0;
    end else begin
      enable_q <= cfg_enable;
      if (enable_rise) begin
        avg_n   <= n_clamped;
        blen_m1 <= (cfg_block_len == 16'd0) ? 16'd0 : cfg_block_len - 16'd1;
      end
    end
  end

  // Partial state only survives while the registered enable is high.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc      <= '0;
      avg_cnt  <= '0;
      lane     <= 1'b0;
      low_word <= '0;
      beat_cnt <= '0;
    end else if (!enable_q) begin
      acc      <= '0;
      avg_cnt  <= '0;
      lane     <= 1'b0;
      beat_cnt <= '0;
    end else if (in_xfer) begin
      if (avg_done) begin
        acc     <= '0;
        avg_cnt <= '0;
        if (lane) begin
          lane     <= 1'b0;
          beat_cnt <= beat_last ? 16'd0 : beat_cnt + 16'd1;
        end else begin
          low_word <= result;
          lane     <= 1'b1;
        end
      end else begin
        acc     <= acc_sum;
        avg_cnt <= avg_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (beat_load) begin
      m_axis_tdata  <= {result, low_word};
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= beat_last;
    end else if (out_xfer) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      block_cnt <= '0;
    end else if (out_xfer && m_axis_tlast) begin
      block_cnt <= block_cnt + 16'd1;
    end
  end

  assign status = {14'd0, lane, enable_q | m_axis_tvalid, block_cnt};

endmodule
`default_nettype wire
